// File: rtl/ppu_pkg.sv
// ppu_pkg: shared definitions for the PPU CPU-facing register port.
// Holds the register select encoding, the PPUSTATUS bit positions, the VRAM
// address increment steps and the palette page used by the optional bypass.
package ppu_pkg;

  // CPU A[2:0] register select inside the $2000-$2007 window
  typedef enum logic [2:0] {
    PPUCTRL   = 3'd0,
    PPUMASK   = 3'd1,
    PPUSTATUS = 3'd2,
    OAMADDR   = 3'd3,
    OAMDATA   = 3'd4,
    PPUSCROLL = 3'd5,
    PPUADDR   = 3'd6,
    PPUDATA   = 3'd7
  } reg_addr_e;

  // PPUSTATUS bit positions; bits [4:0] read back the open-bus latch
  localparam int STAT_VBLANK = 7;
  localparam int STAT_SPR0   = 6;
  localparam int STAT_OVF    = 5;

  // PPUDATA accesses step v across a row or down a column
  localparam logic [14:0] VRAM_INC_ACROSS = 15'd1;
  localparam logic [14:0] VRAM_INC_DOWN   = 15'd32;

  // v[13:8] value of the palette page
  localparam logic [5:0] PALETTE_PAGE = 6'h3F;

  // 15-bit wrapping increment of the VRAM address register
  function automatic logic [14:0] vram_inc(input logic [14:0] v, input logic down);
    return v + (down ? VRAM_INC_DOWN : VRAM_INC_ACROSS);
  endfunction

endpackage

// File: rtl/ppu_cpu_port_if.sv
// ppu_cpu_port_if: CPU register bus between the 2A03 address decoder and the
// PPU register port.
//
// Bus protocol: cs is a one-cycle access strobe with no ready/back-pressure;
// rw, addr and d_in are qualified by cs in the same cycle and the access is
// accepted at that rising edge. A read returns d_out one cycle later (two for
// a bypassed palette read) and d_out then holds until the next read returns.
interface ppu_cpu_port_if;
  logic       cs;
  logic       rw;
  logic [2:0] addr;
  logic [7:0] d_in;
  logic [7:0] d_out;

  modport master (output cs, rw, addr, d_in, input d_out);
  modport slave  (input cs, rw, addr, d_in, output d_out);
endinterface

// File: rtl/ppu_loopy_regs.sv
// ppu_loopy_regs: the shared scroll/address latches t, v, x and the write
// toggle w. $2005/$2006 writes fill t (and x) in two halves selected by w,
// the second $2006 write copies t into v, and PPUDATA accesses step v.
module ppu_loopy_regs
  import ppu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,     // CPU write accepted this cycle
  input  reg_addr_e   sel,       // register being accessed
  input  logic [7:0]  d,         // CPU write data
  input  logic        clr_w,     // PPUSTATUS read resets the toggle
  input  logic        inc_en,    // PPUDATA access steps v
  input  logic        inc_down,  // step by 32 instead of 1
  output logic [14:0] t,
  output logic [13:0] v_addr,
  output logic [2:0]  x
);

  logic [14:0] v;
  logic        w;

  assign v_addr = v[13:0];

  // t/v/x/w update on register writes, toggle reset and PPUDATA stepping
  always_ff @(posedge clk) begin
    if (!rst) begin
      t <= '0;
      v <= '0;
      x <= '0;
      w <= 1'b0;
    end else begin
      if (clr_w) w <= 1'b0;
      if (inc_en) v <= vram_inc(v, inc_down);
      if (wr_en) begin
        case (sel)
          PPUCTRL: t[11:10] <= d[1:0];
          PPUSCROLL: begin
            if (!w) begin
              t[4:0] <= d[7:3];
              x      <= d[2:0];
              w      <= 1'b1;
            end else begin
              t[14:12] <= d[2:0];
              t[9:5]   <= d[7:3];
              w        <= 1'b0;
            end
          end
          PPUADDR: begin
            if (!w) begin
              t[13:8] <= d[5:0];
              t[14]   <= 1'b0;
              w       <= 1'b1;
            end else begin
              t[7:0] <= d;
              v      <= {t[14:8], d};
              w      <= 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: rtl/ppu_cpu_port.sv
// ppu_cpu_port: CPU-facing register port of the PPU ($2000-$2007).
// Decodes strobed reads/writes, holds PPUCTRL/PPUMASK/status/OAMADDR, the
// PPUDATA read buffer and the open-bus latch, and drives the VRAM/OAM access
// strobes combinationally in the access cycle.
// Optional feature macro: PPU_PALETTE_BYPASS_EN -- PPUDATA reads from the
// palette page return the memory byte directly (two cycles after cs) while
// the read buffer still loads. Without it every PPUDATA read is buffered.
module ppu_cpu_port
  import ppu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  ppu_cpu_port_if.slave bus,
  output logic [13:0]  vram_addr,
  output logic [7:0]   vram_wdata,
  output logic         vram_we,
  output logic         vram_re,
  input  logic [7:0]   vram_rdata,
  output logic [7:0]   oam_addr,
  output logic [7:0]   oam_wdata,
  output logic         oam_we,
  input  logic [7:0]   oam_rdata,
  input  logic         vbl_start,
  input  logic         vbl_end,
  input  logic         spr0_hit,
  input  logic         spr_ovf,
  output logic [7:0]   ppu_ctrl,
  output logic [7:0]   ppu_mask,
  output logic [14:0]  scroll_t,
  output logic [2:0]   fine_x,
  output logic         nmi
);

  logic [7:0] ctrl;
  logic [7:0] mask;
  logic [7:0] latch;       // open-bus byte: last byte written or returned
  logic [7:0] rd_buf;      // PPUDATA read buffer
  logic       pend_load;   // rd_buf loads from vram_rdata this cycle
  logic       vblank;
  logic       spr0;
  logic       ovf;

  reg_addr_e  sel;
  logic       rd_acc;
  logic       wr_acc;
  logic       stat_rd;
  logic       data_rd;
  logic       data_wr;
  logic       rd_returns;  // this read updates d_out at the coming edge
  logic [7:0] buf_now;
  logic [7:0] status_byte;
  logic [7:0] rd_byte;

  assign sel     = reg_addr_e'(bus.addr);
  assign rd_acc  = bus.cs & bus.rw;
  assign wr_acc  = bus.cs & ~bus.rw;
  assign stat_rd = rd_acc & (sel == PPUSTATUS);
  assign data_rd = rd_acc & (sel == PPUDATA);
  assign data_wr = wr_acc & (sel == PPUDATA);

  // A buffer load landing in the same cycle as a new PPUDATA read is forwarded
  assign buf_now = pend_load ? vram_rdata : rd_buf;

`ifdef PPU_PALETTE_BYPASS_EN
  logic pal_hit;
  logic pend_pal;          // palette byte arrives on vram_rdata this cycle
  assign pal_hit    = (vram_addr[13:8] == PALETTE_PAGE);
  assign rd_returns = rd_acc & ~(data_rd & pal_hit);
`else
  assign rd_returns = rd_acc;
`endif

  assign vram_we    = data_wr;
  assign vram_re    = data_rd;
  assign vram_wdata = bus.d_in;
  assign oam_we     = wr_acc & (sel == OAMDATA);
  assign oam_wdata  = bus.d_in;

  assign ppu_ctrl = ctrl;
  assign ppu_mask = mask;
  assign nmi      = vblank & ctrl[7];

  // PPUSTATUS image; a read racing vbl_start reports vblank clear
  always_comb begin
    status_byte              = {3'b000, latch[4:0]};
    status_byte[STAT_VBLANK] = vblank & ~vbl_start;
    status_byte[STAT_SPR0]   = spr0;
    status_byte[STAT_OVF]    = ovf;
  end

  // Byte returned by a read; write-only registers return the open-bus latch
  always_comb begin
    rd_byte = latch;
    case (sel)
      PPUSTATUS: rd_byte = status_byte;
      OAMDATA:   rd_byte = oam_rdata;
      PPUDATA:   rd_byte = buf_now;
      default:   rd_byte = latch;
    endcase
  end

  // Status flags: vbl_start beats any clear, vbl_end beats sprite sets
  always_ff @(posedge clk) begin
    if (!rst) begin
      vblank <= 1'b0;
      spr0   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (vbl_start) vblank <= 1'b1;
      else if (vbl_end || stat_rd) vblank <= 1'b0;
      if (vbl_end) begin
        spr0 <= 1'b0;
        ovf  <= 1'b0;
      end else begin
        if (spr0_hit) spr0 <= 1'b1;
        if (spr_ovf)  ovf  <= 1'b1;
      end
    end
  end

  // Register writes, read data return, open-bus latch and buffer loading
  always_ff @(posedge clk) begin
    if (!rst) begin
      ctrl      <= '0;
      mask      <= '0;
      oam_addr  <= '0;
      latch     <= '0;
      rd_buf    <= '0;
      pend_load <= 1'b0;
      bus.d_out <= '0;
`ifdef PPU_PALETTE_BYPASS_EN
      pend_pal  <= 1'b0;
`endif
    end else begin
      pend_load <= data_rd;
      if (pend_load) rd_buf <= vram_rdata;
`ifdef PPU_PALETTE_BYPASS_EN
      // Deferred palette return; a read accepted at this same edge wins
      pend_pal <= data_rd & pal_hit;
      if (pend_pal) begin
        bus.d_out <= vram_rdata;
        latch     <= vram_rdata;
      end
`endif
      if (wr_acc) begin
        latch <= bus.d_in;
        case (sel)
          PPUCTRL: ctrl     <= bus.d_in;
          PPUMASK: mask     <= bus.d_in;
          OAMADDR: oam_addr <= bus.d_in;
          OAMDATA: oam_addr <= oam_addr + 8'd1;
          default: ;
        endcase
      end
      if (rd_returns) begin
        bus.d_out <= rd_byte;
        latch     <= rd_byte;
      end
    end
  end

  ppu_loopy_regs u_loopy (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_acc),
    .sel      (sel),
    .d        (bus.d_in),
    .clr_w    (stat_rd),
    .inc_en   (data_rd | data_wr),
    .inc_down (ctrl[2]),
    .t        (scroll_t),
    .v_addr   (vram_addr),
    .x        (fine_x)
  );

endmodule

// File: tb/tb_ppu_cpu_port.sv
// tb_ppu_cpu_port: randomized and directed stimulus for ppu_cpu_port against
// a sequential register-level reference model, with a scoreboard monitor.
module tb_ppu_cpu_port;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  ppu_cpu_port_if bus ();

  logic [13:0] vram_addr;
  logic [7:0]  vram_wdata;
  logic        vram_we;
  logic        vram_re;
  logic [7:0]  vram_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic [7:0]  oam_rdata;
  logic        vbl_start, vbl_end, spr0_hit, spr_ovf;
  logic [7:0]  ppu_ctrl, ppu_mask;
  logic [14:0] scroll_t;
  logic [2:0]  fine_x;
  logic        nmi;

  ppu_cpu_port dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .vram_addr  (vram_addr),
    .vram_wdata (vram_wdata),
    .vram_we    (vram_we),
    .vram_re    (vram_re),
    .vram_rdata (vram_rdata),
    .oam_addr   (oam_addr),
    .oam_wdata  (oam_wdata),
    .oam_we     (oam_we),
    .oam_rdata  (oam_rdata),
    .vbl_start  (vbl_start),
    .vbl_end    (vbl_end),
    .spr0_hit   (spr0_hit),
    .spr_ovf    (spr_ovf),
    .ppu_ctrl   (ppu_ctrl),
    .ppu_mask   (ppu_mask),
    .scroll_t   (scroll_t),
    .fine_x     (fine_x),
    .nmi        (nmi)
  );

  // ---------------- memories (static contents) ----------------
  logic [7:0] vmem [0:16383];
  logic [7:0] omem [0:255];

  assign oam_rdata = omem[oam_addr];

  // VRAM answers exactly one cycle after vram_re; junk otherwise
  always @(posedge clk) vram_rdata <= vram_re ? vmem[vram_addr] : 8'($urandom);

  // ---------------- scoreboard ----------------
  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0]  exp_q    [$];  // read data returned on d_out
  logic [21:0] exp_vw_q [$];  // {vram_addr, vram_wdata} per vram_we
  logic [13:0] exp_re_q [$];  // vram_addr per vram_re
  logic [15:0] exp_ow_q [$];  // {oam_addr, oam_wdata} per oam_we

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_ctrl, m_mask, m_oam, m_latch, m_buf;
  logic [14:0] m_t, m_v;
  logic [2:0]  m_x;
  logic        m_w, m_vbl, m_spr0, m_ovf;

  task automatic model_reset();
    m_ctrl = 0; m_mask = 0; m_oam = 0; m_latch = 0; m_buf = 0;
    m_t = 0; m_v = 0; m_x = 0; m_w = 0; m_vbl = 0; m_spr0 = 0; m_ovf = 0;
  endtask

  function automatic logic [14:0] step_v(input logic [14:0] v, input logic down);
    int n;
    n = int'(v) + (down ? 32 : 1);
    return 15'(n % 32768);
  endfunction

  // One bus cycle: optional access plus event pulses, in register-level terms
  task automatic model_step(input logic is_acc, input logic rw_i, input logic [2:0] a,
                            input logic [7:0] d, input logic [3:0] ev);
    logic vs, ve, s0, ov, rd2002;
    logic [7:0] r;
    {vs, ve, s0, ov} = ev;
    rd2002 = is_acc && rw_i && (a == 3'd2);
    if (is_acc && rw_i) begin
      case (a)
        3'd2: r = {(vs ? 1'b0 : m_vbl), m_spr0, m_ovf, m_latch[4:0]};
        3'd4: r = omem[m_oam];
        3'd7: begin
          exp_re_q.push_back(m_v[13:0]);
          r     = m_buf;
          m_buf = vmem[m_v[13:0]];
          m_v   = step_v(m_v, m_ctrl[2]);
        end
        default: r = m_latch;
      endcase
      m_latch = r;
      exp_q.push_back(r);
      if (a == 3'd2) m_w = 1'b0;
    end
    if (ve || rd2002) m_vbl = 1'b0;
    if (vs) m_vbl = 1'b1;
    if (s0) m_spr0 = 1'b1;
    if (ov) m_ovf = 1'b1;
    if (ve) begin m_spr0 = 1'b0; m_ovf = 1'b0; end
    if (is_acc && !rw_i) begin
      m_latch = d;
      case (a)
        3'd0: begin m_ctrl = d; m_t[11:10] = d[1:0]; end
        3'd1: m_mask = d;
        3'd3: m_oam = d;
        3'd4: begin exp_ow_q.push_back({m_oam, d}); m_oam = m_oam + 8'd1; end
        3'd5: begin
          if (!m_w) begin m_t[4:0] = d[7:3]; m_x = d[2:0]; m_w = 1'b1; end
          else begin m_t[14:12] = d[2:0]; m_t[9:5] = d[7:3]; m_w = 1'b0; end
        end
        3'd6: begin
          if (!m_w) begin m_t[13:8] = d[5:0]; m_t[14] = 1'b0; m_w = 1'b1; end
          else begin m_t[7:0] = d; m_v = m_t; m_w = 1'b0; end
        end
        3'd7: begin
          exp_vw_q.push_back({m_v[13:0], d});
          m_v = step_v(m_v, m_ctrl[2]);
        end
        default: ;
      endcase
    end
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic acc(input logic rw_i, input logic [2:0] a, input logic [7:0] d,
                     input logic [3:0] ev);
    bus.cs = 1'b1; bus.rw = rw_i; bus.addr = a; bus.d_in = d;
    {vbl_start, vbl_end, spr0_hit, spr_ovf} = ev;
    model_step(1'b1, rw_i, a, d, ev);
    @(negedge clk);
    bus.cs = 1'b0;
    {vbl_start, vbl_end, spr0_hit, spr_ovf} = 4'b0;
  endtask

  task automatic ev_only(input logic [3:0] ev);
    bus.cs = 1'b0;
    {vbl_start, vbl_end, spr0_hit, spr_ovf} = ev;
    model_step(1'b0, 1'b0, 3'd0, 8'd0, ev);
    @(negedge clk);
    {vbl_start, vbl_end, spr0_hit, spr_ovf} = 4'b0;
  endtask

  task automatic idle(input int n);
    bus.cs = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.cs = 1'b0;
    {vbl_start, vbl_end, spr0_hit, spr_ovf} = 4'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic check_state();
    chk("vram_addr", 32'(vram_addr), 32'(m_v[13:0]));
    chk("scroll_t",  32'(scroll_t),  32'(m_t));
    chk("fine_x",    32'(fine_x),    32'(m_x));
    chk("ppu_ctrl",  32'(ppu_ctrl),  32'(m_ctrl));
    chk("ppu_mask",  32'(ppu_mask),  32'(m_mask));
    chk("oam_addr",  32'(oam_addr),  32'(m_oam));
    chk("nmi",       32'(nmi),       32'(m_vbl & m_ctrl[7]));
  endtask

  // ---------------- monitor: pops and compares on DUT activity ----------------
  initial begin : monitor
    logic prev_rd;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (prev_rd) begin
        if (exp_q.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
        else chk("rd_data", 32'(bus.d_out), 32'(exp_q.pop_front()));
      end
      prev_rd = bus.cs & bus.rw & rst;
      if (vram_we) begin
        if (exp_vw_q.size() == 0) chk("vram_we_unexpected", 32'd1, 32'd0);
        else chk("vram_write", 32'({vram_addr, vram_wdata}), 32'(exp_vw_q.pop_front()));
      end
      if (vram_re) begin
        if (exp_re_q.size() == 0) chk("vram_re_unexpected", 32'd1, 32'd0);
        else chk("vram_read_addr", 32'(vram_addr), 32'(exp_re_q.pop_front()));
      end
      if (oam_we) begin
        if (exp_ow_q.size() == 0) chk("oam_we_unexpected", 32'd1, 32'd0);
        else chk("oam_write", 32'({oam_addr, oam_wdata}), 32'(exp_ow_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [2:0] a;
    logic       rw_r;
    logic [7:0] d;
    logic [3:0] ev;

    rst = 1'b0;
    bus.cs = 1'b0; bus.rw = 1'b0; bus.addr = 3'd0; bus.d_in = 8'd0;
    {vbl_start, vbl_end, spr0_hit, spr_ovf} = 4'b0;
    for (int i = 0; i < 16384; i++) vmem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) omem[i] = 8'($urandom);
    vmem[14'h2000] = 8'h11;
    vmem[14'h2020] = 8'h22;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // reset state
    check_state();
    acc(1'b1, 3'd2, 8'h00, 4'b0);
    chk("reset_status_read", 32'(bus.d_out), 32'h00);
    chk("reset_nmi", 32'(nmi), 32'd0);

    // $2006 address load and a PPUDATA write
    acc(1'b0, 3'd6, 8'h21, 4'b0);
    acc(1'b0, 3'd6, 8'h08, 4'b0);
    chk("addr_load", 32'(vram_addr), 32'h2108);
    acc(1'b0, 3'd7, 8'hAB, 4'b0);
    chk("addr_after_write", 32'(vram_addr), 32'h2109);

    // back-to-back buffered reads stepping by 32
    acc(1'b0, 3'd0, 8'h04, 4'b0);
    acc(1'b0, 3'd6, 8'h20, 4'b0);
    acc(1'b0, 3'd6, 8'h00, 4'b0);
    acc(1'b1, 3'd7, 8'h00, 4'b0);
    chk("buffered_read_1", 32'(bus.d_out), 32'h00);
    acc(1'b1, 3'd7, 8'h00, 4'b0);
    chk("buffered_read_2", 32'(bus.d_out), 32'h11);
    chk("addr_step32", 32'(vram_addr), 32'h2040);

    // scroll writes
    acc(1'b0, 3'd5, 8'h7D, 4'b0);
    acc(1'b0, 3'd5, 8'h5E, 4'b0);
    chk("fine_x", 32'(fine_x), 32'd5);
    chk("scroll_t", 32'(scroll_t), 32'h616F);

    // vblank, NMI and status read side effects
    acc(1'b0, 3'd0, 8'h80, 4'b0);
    ev_only(4'b1000);
    chk("nmi_on_vblank", 32'(nmi), 32'd1);
    acc(1'b0, 3'd5, 8'h03, 4'b0);
    acc(1'b1, 3'd2, 8'h00, 4'b0);
    chk("status_vblank_bit", 32'(bus.d_out[7]), 32'd1);
    chk("nmi_after_status", 32'(nmi), 32'd0);
    acc(1'b0, 3'd5, 8'h06, 4'b0);
    chk("toggle_cleared", 32'(fine_x), 32'd6);
    acc(1'b1, 3'd2, 8'h00, 4'b1000);
    chk("status_race_bit7", 32'(bus.d_out[7]), 32'd0);
    chk("status_race_nmi", 32'(nmi), 32'd1);

    // sprite flags: clear wins over a coincident hit
    ev_only(4'b0011);
    acc(1'b1, 3'd2, 8'h00, 4'b0);
    chk("spr_flags_set", 32'(bus.d_out[6:5]), 32'd3);
    ev_only(4'b0110);
    acc(1'b1, 3'd2, 8'h00, 4'b0);
    chk("spr0_clear_wins", 32'(bus.d_out[6]), 32'd0);

    // OAM address wrap
    acc(1'b0, 3'd3, 8'hFF, 4'b0);
    acc(1'b0, 3'd4, 8'h3C, 4'b0);
    chk("oam_wrap", 32'(oam_addr), 32'h00);
    acc(1'b1, 3'd4, 8'h00, 4'b0);
    check_state();

    // reset in the middle of a two-write sequence with a buffer load pending
    acc(1'b0, 3'd6, 8'h12, 4'b0);
    acc(1'b1, 3'd7, 8'h00, 4'b0);
    do_reset();
    check_state();
    acc(1'b0, 3'd6, 8'h15, 4'b0);
    chk("toggle_after_reset", 32'(scroll_t), 32'h1500);
    acc(1'b1, 3'd7, 8'h00, 4'b0);
    chk("buffer_after_reset", 32'(bus.d_out), 32'h00);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      a    = 3'($urandom_range(0, 7));
      rw_r = 1'($urandom_range(0, 1));
      d    = 8'($urandom);
      ev   = {($urandom_range(0, 9) == 0), ($urandom_range(0, 11) == 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
      if ($urandom_range(0, 3) == 0) a = 3'd7;
      if (rw_r && a == 3'd7 && m_v[13:8] == 6'h3F) a = 3'd2;
      if ($urandom_range(0, 5) == 0) ev_only(ev);
      else acc(rw_r, a, d, ev);
      if ($urandom_range(0, 3) == 0) check_state();
      if ($urandom_range(0, 9) == 0) idle(1);
    end
    idle(3);
    check_state();

    chk("rd_queue_drained",  32'(exp_q.size()),    32'd0);
    chk("vw_queue_drained",  32'(exp_vw_q.size()), 32'd0);
    chk("re_queue_drained",  32'(exp_re_q.size()), 32'd0);
    chk("ow_queue_drained",  32'(exp_ow_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
